// File: rtl/l2_arb_pkg.sv
// rtl/l2_arb_pkg.sv - shared types and helpers for the L2 read arbiter
//
// Contents:
//   L2_ADDR_W/L2_ID_W/L2_SIZE_W  default field widths of a tile read request
//   src_w()                      width of the source index stamped into the ID
//   grant_state_t                request-side grant FSM states
//   l2_rd_req_t                  packed {addr, id, size} read request
package l2_arb_pkg;

  localparam int L2_ADDR_W = 40;
  localparam int L2_ID_W   = 4;
  localparam int L2_SIZE_W = 3;

  // A single requester still needs one bit so the ID concatenation stays legal.
  function automatic int src_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  typedef enum logic [0:0] {
    GRANT_IDLE = 1'b0,
    GRANT_HOLD = 1'b1
  } grant_state_t;

  typedef struct packed {
    logic [L2_ADDR_W-1:0] addr;
    logic [L2_ID_W-1:0]   id;
    logic [L2_SIZE_W-1:0] size;
  } l2_rd_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick from a request vector
//
// Ports:
//   req_i        per-index request (already qualified by the caller)
//   ptr_i        highest-priority index this cycle (must be < NUM_REQ)
//   gnt_o        one-hot grant
//   gnt_idx_o    encoded grant index
//   gnt_valid_o  at least one request present
module rr_arbiter
  import l2_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int SRC_W   = src_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [SRC_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [SRC_W-1:0]   gnt_idx_o,
  output logic               gnt_valid_o
);

  localparam logic [SRC_W:0] NUM_REQ_W = (SRC_W+1)'(NUM_REQ);

  logic [SRC_W:0]   w_sum;
  logic [SRC_W-1:0] w_idx;

  // Walk offsets from farthest to nearest so the nearest requester past the
  // pointer is the last (winning) assignment.
  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    w_sum       = '0;
    w_idx       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, ptr_i} + (SRC_W+1)'(k);
      if (w_sum >= NUM_REQ_W) begin
        w_sum = w_sum - NUM_REQ_W;
      end
      w_idx = w_sum[SRC_W-1:0];
      if (req_i[w_idx]) begin
        gnt_o        = '0;
        gnt_o[w_idx] = 1'b1;
        gnt_idx_o    = w_idx;
        gnt_valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/l2_read_arbiter.sv
// rtl/l2_read_arbiter.sv - shares one L2 read channel among NUM_REQ requesters
//
// Ports:
//   clk_i, rstn_i        clock, synchronous active-low reset
//   req_*                per-requester read requests (valid/ready, addr/id/size)
//   mem_req_*            arbitrated downstream request, ID = {source, upstream ID}
//   mem_resp_*           downstream response beats, routed by the ID source bits
//   resp_*               per-requester valid/ready, shared id/data/last buses
//   route_err_o          sticky: a response carried a source index >= NUM_REQ
module l2_read_arbiter
  import l2_arb_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int ADDR_W    = L2_ADDR_W,
  parameter int ID_W      = L2_ID_W,
  parameter int DATA_W    = 512,
  parameter int SIZE_W    = L2_SIZE_W,
  parameter int MAX_OUTST = 4
) (
  input  logic                              clk_i,
  input  logic                              rstn_i,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  input  logic [NUM_REQ*ADDR_W-1:0]         req_addr_i,
  input  logic [NUM_REQ*ID_W-1:0]           req_id_i,
  input  logic [NUM_REQ*SIZE_W-1:0]         req_size_i,
  output logic                              mem_req_valid_o,
  input  logic                              mem_req_ready_i,
  output logic [ADDR_W-1:0]                 mem_req_addr_o,
  output logic [ID_W+src_w(NUM_REQ)-1:0]    mem_req_id_o,
  output logic [SIZE_W-1:0]                 mem_req_size_o,
  input  logic                              mem_resp_valid_i,
  output logic                              mem_resp_ready_o,
  input  logic [ID_W+src_w(NUM_REQ)-1:0]    mem_resp_id_i,
  input  logic [DATA_W-1:0]                 mem_resp_data_i,
  input  logic                              mem_resp_last_i,
  output logic [NUM_REQ-1:0]                resp_valid_o,
  input  logic [NUM_REQ-1:0]                resp_ready_i,
  output logic [ID_W-1:0]                   resp_id_o,
  output logic [DATA_W-1:0]                 resp_data_o,
  output logic                              resp_last_o,
  output logic                              route_err_o
);

  localparam int               SRC_W     = src_w(NUM_REQ);
  localparam int               CNT_W     = 4;
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_OUTST);
  localparam logic [SRC_W:0]   NUM_REQ_W = (SRC_W+1)'(NUM_REQ);

  grant_state_t     r_state;
  logic [SRC_W-1:0] r_gnt_idx;
  logic [SRC_W-1:0] r_rr_ptr;
  logic [CNT_W-1:0] r_cnt [NUM_REQ];
  logic             r_route_err;

  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_arb_gnt;
  logic [SRC_W-1:0]   w_arb_idx;
  logic               w_arb_valid;
  logic [NUM_REQ-1:0] w_sel_oh;
  logic [SRC_W-1:0]   w_sel_idx;
  logic               w_sel_valid;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [ID_W-1:0]    w_sel_id;
  logic [SIZE_W-1:0]  w_sel_size;
  logic               w_req_hs;
  logic [SRC_W-1:0]   w_src;
  logic               w_src_ok;
  logic               w_route_rdy;
  logic               w_resp_hs;
  logic [NUM_REQ-1:0] w_dec;
  logic [NUM_REQ-1:0] w_underflow;

  function automatic logic [SRC_W-1:0] f_next(input logic [SRC_W-1:0] idx);
    logic [SRC_W:0] s;
    s = {1'b0, idx} + 1'b1;
    return (s >= NUM_REQ_W) ? '0 : s[SRC_W-1:0];
  endfunction

  // A requester at its outstanding limit is invisible to arbitration.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_elig[i] = req_valid_i[i] && (r_cnt[i] < MAX_CNT);
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .SRC_W   (SRC_W)
  ) u_rr_arbiter (
    .req_i       (w_elig),
    .ptr_i       (r_rr_ptr),
    .gnt_o       (w_arb_gnt),
    .gnt_idx_o   (w_arb_idx),
    .gnt_valid_o (w_arb_valid)
  );

  // Request path: in HOLD the grant stays on the latched index even if a
  // higher-priority requester shows up.
  always_comb begin
    w_sel_oh    = '0;
    w_sel_addr  = '0;
    w_sel_id    = '0;
    w_sel_size  = '0;
    w_sel_idx   = (r_state == GRANT_HOLD) ? r_gnt_idx : w_arb_idx;
    w_sel_valid = (r_state == GRANT_HOLD) ? req_valid_i[r_gnt_idx] : w_arb_valid;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sel_oh[i] = (r_state == GRANT_HOLD) ? (r_gnt_idx == SRC_W'(i)) : w_arb_gnt[i];
      if (w_sel_oh[i]) begin
        w_sel_addr = req_addr_i[i*ADDR_W +: ADDR_W];
        w_sel_id   = req_id_i[i*ID_W +: ID_W];
        w_sel_size = req_size_i[i*SIZE_W +: SIZE_W];
      end
    end
  end

  assign mem_req_valid_o = rstn_i && w_sel_valid;
  assign mem_req_addr_o  = w_sel_addr;
  assign mem_req_id_o    = {w_sel_idx, w_sel_id};
  assign mem_req_size_o  = w_sel_size;
  assign w_req_hs        = mem_req_valid_o && mem_req_ready_i;
  assign req_ready_o     = w_req_hs ? w_sel_oh : '0;

  // Response path: pure pass-through steered by the source bits. Beats with an
  // out-of-range source are swallowed so the downstream channel cannot wedge.
  assign w_src    = mem_resp_id_i[ID_W +: SRC_W];
  assign w_src_ok = ({1'b0, w_src} < NUM_REQ_W);

  always_comb begin
    resp_valid_o = '0;
    w_route_rdy  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_valid_o[i] = rstn_i && mem_resp_valid_i && (w_src == SRC_W'(i));
      if (w_src == SRC_W'(i)) begin
        w_route_rdy = resp_ready_i[i];
      end
    end
  end

  assign mem_resp_ready_o = rstn_i && (w_src_ok ? w_route_rdy : 1'b1);
  assign w_resp_hs        = mem_resp_valid_i && mem_resp_ready_o;
  assign resp_id_o        = mem_resp_id_i[ID_W-1:0];
  assign resp_data_o      = mem_resp_data_i;
  assign resp_last_o      = mem_resp_last_i;
  assign route_err_o      = r_route_err;

  always_comb begin
    w_dec       = '0;
    w_underflow = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_dec[i]       = w_resp_hs && mem_resp_last_i && resp_valid_o[i];
      w_underflow[i] = w_dec[i] && !req_ready_o[i] && (r_cnt[i] == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state     <= GRANT_IDLE;
      r_gnt_idx   <= '0;
      r_rr_ptr    <= '0;
      r_route_err <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      case (r_state)
        GRANT_IDLE: begin
          if (w_arb_valid) begin
            if (mem_req_ready_i) begin
              r_rr_ptr <= f_next(w_arb_idx);
            end else begin
              r_gnt_idx <= w_arb_idx;
              r_state   <= GRANT_HOLD;
            end
          end
        end
        GRANT_HOLD: begin
          if (w_req_hs) begin
            r_rr_ptr <= f_next(r_gnt_idx);
            r_state  <= GRANT_IDLE;
          end
        end
        default: r_state <= GRANT_IDLE;
      endcase

      if (w_resp_hs && !w_src_ok) begin
        r_route_err <= 1'b1;
      end

      // Simultaneous issue and retire cancel out; retire at zero saturates.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready_o[i] && !w_dec[i]) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end else if (w_dec[i] && !req_ready_o[i] && (r_cnt[i] != '0)) begin
          r_cnt[i] <= r_cnt[i] - 1'b1;
        end
      end
    end
  end

  a_hold_valid_stable: assert property (@(posedge clk_i) disable iff (!rstn_i)
    (r_state == GRANT_HOLD) |-> req_valid_i[r_gnt_idx]);

  a_no_cnt_underflow: assert property (@(posedge clk_i) disable iff (!rstn_i)
    (w_underflow == '0));

endmodule
